// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, TX FIFO depth and pointer sizing.
// Imported by the UART FIFO and datapath modules.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_TXFIFO_DEPTH = 16;

    // Pointer width for a power-of-two FIFO: index bits plus one wrap bit.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int UART_TXFIFO_PTR_W = fifo_ptr_w(UART_TXFIFO_DEPTH);

endpackage

// File: rtl/uart_fifo_mem.sv
// Flop-based storage array with one synchronous write port and one
// combinational read port; shared by the TX and RX FIFOs.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write index
//   wdata - write data
//   raddr - read index
//   rdata - read data (combinational from the array)
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of uart_tx: bus-side write port, show-ahead
// read port to the transmitter, occupancy, low-watermark irq, sticky ovf.
// Ports:
//   clk, rst             - clock, async active-high reset
//   cfg_txen, cfg_flush  - transmitter enable, synchronous flush
//   cfg_wm               - low-watermark level
//   ovf_clear            - clears sticky overflow flag
//   wr_valid/wr_data/wr_ready - bus-side write handshake
//   tx_valid/tx_data/tx_ready - transmitter-side handshake
//   count, full, empty, ovf, irq_txwm - status
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TXFIFO_DEPTH,
    parameter int WIDTH = UART_DATA_W,
    parameter int PW    = fifo_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_txen,
    input  logic             cfg_flush,
    input  logic [PW-1:0]    cfg_wm,
    input  logic             ovf_clear,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ready,
    output logic [PW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             irq_txwm
);

    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // All flow-control outputs decode from registered state only.
    assign full     = (count == PW'(DEPTH));
    assign empty    = (count == '0);
    assign wr_ready = !full;
    assign tx_valid = !empty;
    assign irq_txwm = (count <= cfg_wm);

    // A byte only leaves when the transmitter is enabled.
    assign push = wr_valid & wr_ready;
    assign pop  = tx_valid & tx_ready & cfg_txen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (cfg_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + PW'(1);
            end else if (pop && !push) begin
                count <= count - PW'(1);
            end
        end
    end

    // Set has priority over clear so no overflow event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wr_valid && full) begin
            ovf <= 1'b1;
        end else if (ovf_clear) begin
            ovf <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push & !cfg_flush),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (tx_data)
    );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table for basic handshakes
// plus directed sequences for fill/overflow/drain, wrap, watermark, flush, reset.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       cfg_txen;
    logic       cfg_flush;
    logic [4:0] cfg_wm;
    logic       ovf_clear;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       irq_txwm;

    int n_cmp;
    int n_err;

    uart_tx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_txen  (cfg_txen),
        .cfg_flush (cfg_flush),
        .cfg_wm    (cfg_wm),
        .ovf_clear (ovf_clear),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .irq_txwm  (irq_txwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rdy;
        logic       en;
        logic       fl;
        logic [4:0] e_cnt;
        logic       e_tv;
        logic       e_full;
        logic       e_irq;
        logic       e_dchk;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [7:0] base);
        cfg_txen = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            wr_data = base + 8'(i);
            step();
        end
        wr_valid = 1'b0;
    endtask

    task automatic drain_chk(input int n, input logic [7:0] base,
                             input string name);
        cfg_txen = 1'b1;
        tx_ready = 1'b1;
        wr_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk(name, {24'd0, tx_data}, {24'd0, base + 8'(i)});
            step();
        end
        tx_ready = 1'b0;
        cfg_txen = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        cfg_txen  = 1'b0;
        cfg_flush = 1'b0;
        cfg_wm    = 5'd0;
        ovf_clear = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        tx_ready  = 1'b0;

        tbl[0] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55};
        tbl[1] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66};
        tbl[2] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66};
        tbl[3] = '{1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'h66};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'h66};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h88};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[8] = '{1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h99};
        tbl[9] = '{1'b1, 8'hAB, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};

        #3;
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_empty",    {31'd0, empty},    32'd1);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_count",    {27'd0, count},    32'd0);
        chk("rst_irq",      {31'd0, irq_txwm}, 32'd1);
        chk("rst_full",     {31'd0, full},     32'd0);
        chk("rst_ovf",      {31'd0, ovf},      32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Table: basic push/pop/enable/flush behaviour, watermark 2.
        cfg_wm = 5'd2;
        for (int i = 0; i < 10; i++) begin
            wr_valid  = tbl[i].wv;
            wr_data   = tbl[i].wd;
            tx_ready  = tbl[i].rdy;
            cfg_txen  = tbl[i].en;
            cfg_flush = tbl[i].fl;
            step();
            chk($sformatf("v%0d_count", i), {27'd0, count}, {27'd0, tbl[i].e_cnt});
            chk($sformatf("v%0d_txv", i), {31'd0, tx_valid}, {31'd0, tbl[i].e_tv});
            chk($sformatf("v%0d_full", i), {31'd0, full}, {31'd0, tbl[i].e_full});
            chk($sformatf("v%0d_irq", i), {31'd0, irq_txwm}, {31'd0, tbl[i].e_irq});
            chk($sformatf("v%0d_ovf", i), {31'd0, ovf}, 32'd0);
            if (tbl[i].e_dchk) begin
                chk($sformatf("v%0d_data", i), {24'd0, tx_data}, {24'd0, tbl[i].e_data});
            end
        end
        wr_valid  = 1'b0;
        tx_ready  = 1'b0;
        cfg_txen  = 1'b0;
        cfg_flush = 1'b0;

        // Offset pointers so fills straddle the array end.
        push_n(3, 8'hC0);
        drain_chk(3, 8'hC0, "offset_data");

        for (int r = 0; r < 3; r++) begin
            tx_ready = 1'b1;
            push_n(16, 8'(r * 16));
            chk("fill_full",     {31'd0, full},     32'd1);
            chk("fill_wr_ready", {31'd0, wr_ready}, 32'd0);
            chk("fill_count",    {27'd0, count},    32'd16);
            wr_valid  = 1'b1;
            wr_data   = 8'hAA;
            ovf_clear = (r == 0);
            step();
            wr_valid  = 1'b0;
            ovf_clear = 1'b0;
            chk("ovf_set",       {31'd0, ovf},   32'd1);
            chk("ovf_count",     {27'd0, count}, 32'd16);
            ovf_clear = 1'b1;
            step();
            ovf_clear = 1'b0;
            chk("ovf_clear",     {31'd0, ovf},   32'd0);
            drain_chk(16, 8'(r * 16), "drain_data");
            chk("drain_empty",   {31'd0, empty}, 32'd1);
            chk("drain_count",   {27'd0, count}, 32'd0);
        end

        // Push and pop while full: only the pop happens.
        push_n(16, 8'h40);
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        tx_ready = 1'b1;
        cfg_txen = 1'b1;
        step();
        wr_valid = 1'b0;
        chk("fullpp_count", {27'd0, count},   32'd15);
        chk("fullpp_data",  {24'd0, tx_data}, 32'h41);
        drain_chk(15, 8'h41, "fullpp_drain");
        chk("fullpp_empty", {31'd0, empty},   32'd1);

        // Push and pop at count 5 keeps count and order.
        push_n(5, 8'h10);
        wr_valid = 1'b1;
        tx_ready = 1'b1;
        cfg_txen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'h15 + 8'(i);
            step();
            chk("pp5_count", {27'd0, count},   32'd5);
            chk("pp5_data",  {24'd0, tx_data}, {24'd0, 8'h11 + 8'(i)});
        end
        wr_valid = 1'b0;
        drain_chk(5, 8'h13, "pp5_drain");

        // Low watermark at 4.
        cfg_wm = 5'd4;
        push_n(6, 8'h60);
        chk("wm_c6_irq", {31'd0, irq_txwm}, 32'd0);
        tx_ready = 1'b1;
        cfg_txen = 1'b1;
        step();
        chk("wm_c5_count", {27'd0, count},    32'd5);
        chk("wm_c5_irq",   {31'd0, irq_txwm}, 32'd0);
        step();
        chk("wm_c4_count", {27'd0, count},    32'd4);
        chk("wm_c4_irq",   {31'd0, irq_txwm}, 32'd1);
        tx_ready = 1'b0;
        cfg_txen = 1'b0;

        // Flush at count 7 beats a simultaneous push and pop.
        push_n(3, 8'h70);
        chk("fl_pre_count", {27'd0, count}, 32'd7);
        cfg_flush = 1'b1;
        wr_valid  = 1'b1;
        wr_data   = 8'hFE;
        tx_ready  = 1'b1;
        cfg_txen  = 1'b1;
        step();
        cfg_flush = 1'b0;
        wr_valid  = 1'b0;
        chk("fl_count",    {27'd0, count},    32'd0);
        chk("fl_empty",    {31'd0, empty},    32'd1);
        chk("fl_tx_valid", {31'd0, tx_valid}, 32'd0);
        step();
        chk("fl_discard",  {27'd0, count},    32'd0);
        push_n(1, 8'h5A);
        chk("fl_after_data", {24'd0, tx_data}, 32'h5A);

        // Async reset in the middle of a drain.
        push_n(4, 8'h80);
        wr_valid = 1'b1;
        wr_data  = 8'hDD;
        tx_ready = 1'b1;
        cfg_txen = 1'b1;
        step();
        chk("mid_count", {27'd0, count},   32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count",    {27'd0, count},    32'd0);
        chk("arst_empty",    {31'd0, empty},    32'd1);
        chk("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("arst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("arst_full",     {31'd0, full},     32'd0);
        chk("arst_irq",      {31'd0, irq_txwm}, 32'd1);
        wr_valid = 1'b0;
        tx_ready = 1'b0;
        cfg_txen = 1'b0;
        #2;
        rst = 1'b0;
        step();
        chk("post_rst_count", {27'd0, count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
